// File: rtl/adc_serial_emulator_pkg.sv
// Shared definitions for the serial ADC emulator: FSM encodings, frame length, oversampling limit.
package adc_emu_defs;

  typedef enum logic {CONV_IDLE, CONV_BUSY} conv_state_t;
  typedef enum logic {SH_IDLE, SH_ACTIVE} sh_state_t;

  // Largest oversampling code honoured; anything above is treated as 0.
  localparam logic [2:0] OS_MAX = 3'd6;

  function automatic int tx_len_of(input int w_data, input int n_chan);
    return w_data * n_chan / 2;
  endfunction

endpackage

// File: rtl/adc_serial_emulator_sync_edge_det.sv
// 2-FF synchronizer followed by a 1-FF edge detector; rise/fall pulse one cycle,
// valid in the third clk_in cycle after the input changes.
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_in,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk_in) begin
    if (rst_in) sr <= '0;
    else        sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/adc_serial_emulator.sv
// Responder model of a 6-channel dual-line serial ADC: CONVST/BUSY handshake and n_CS/SCLK readout.
// Define ADC_EMU_RAMP_EN to replace chan_data_in with an internal per-channel ramp source.
module adc_serial_emulator
  import adc_emu_defs::*;
#(
  parameter int W_DATA = 18,
  parameter int N_CHAN = 6,
  parameter int T_CONV = 200
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [2:0]               adc_os_in,
  input  logic                     adc_convst_in,
  input  logic                     adc_n_cs_in,
  input  logic                     adc_sclk_in,
  input  logic [N_CHAN*W_DATA-1:0] chan_data_in,
  output logic                     adc_busy_out,
  output logic                     adc_data_a_out,
  output logic                     adc_data_b_out,
  output logic [15:0]              conv_count_out
);

  localparam int TX_LEN = tx_len_of(W_DATA, N_CHAN);
  localparam int W_SNAP = W_DATA * N_CHAN;
  localparam int W_TMR  = $clog2((T_CONV << OS_MAX) + 1);
  localparam int W_CNT  = $clog2(TX_LEN + 1);

  logic convst_rise, ncs_rise, ncs_fall, sclk_fall;

  sync_edge_det u_convst (.clk_in, .rst_in, .din(adc_convst_in), .rise(convst_rise), .fall());
  sync_edge_det u_ncs    (.clk_in, .rst_in, .din(adc_n_cs_in),   .rise(ncs_rise),    .fall(ncs_fall));
  sync_edge_det u_sclk   (.clk_in, .rst_in, .din(adc_sclk_in),   .rise(),            .fall(sclk_fall));

  conv_state_t       conv_state, conv_nxt;
  sh_state_t         sh_state, sh_nxt;
  logic [W_TMR-1:0]  conv_len, tmr, tmr_nxt;
  logic [2:0]        os_eff;
  logic              accept;
  logic [W_SNAP-1:0] snapshot, snap_nxt, snap_src;
  logic [TX_LEN-1:0] shift_a, shift_b, sa_nxt, sb_nxt;
  logic [W_CNT-1:0]  bit_cnt, cnt_nxt;

`ifdef ADC_EMU_RAMP_EN
  logic [W_DATA-1:0] ramp [N_CHAN];

  // Snapshot takes the post-increment ramp value, so the first conversion of channel k reads k*1000+k+1.
  always_comb begin
    snap_src = '0;
    for (int k = 0; k < N_CHAN; k++)
      snap_src[(N_CHAN-1-k)*W_DATA +: W_DATA] = ramp[k] + W_DATA'(k + 1);
  end

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < N_CHAN; k++) begin
      if (rst_in)      ramp[k] <= W_DATA'(k * 1000);
      else if (accept) ramp[k] <= snap_src[(N_CHAN-1-k)*W_DATA +: W_DATA];
    end
  end
`else
  assign snap_src = chan_data_in;
`endif

  always_comb begin
    os_eff   = (adc_os_in > OS_MAX) ? 3'd0 : adc_os_in;
    conv_len = W_TMR'(T_CONV) << os_eff;
    conv_nxt = conv_state;
    tmr_nxt  = tmr;
    accept   = 1'b0;
    case (conv_state)
      CONV_IDLE: if (convst_rise) begin
        accept   = 1'b1;
        conv_nxt = CONV_BUSY;
        tmr_nxt  = conv_len - W_TMR'(1);
      end
      CONV_BUSY: if (tmr == '0) conv_nxt = CONV_IDLE;
                 else           tmr_nxt  = tmr - W_TMR'(1);
      default:   conv_nxt = CONV_IDLE;
    endcase
    snap_nxt = accept ? snap_src : snapshot;
  end

  // The load reads snap_nxt so a same-cycle conversion start is reflected in the frame.
  always_comb begin
    sh_nxt  = sh_state;
    sa_nxt  = shift_a;
    sb_nxt  = shift_b;
    cnt_nxt = bit_cnt;
    if (ncs_fall) begin
      sh_nxt  = SH_ACTIVE;
      sa_nxt  = snap_nxt[W_SNAP-1 -: TX_LEN];
      sb_nxt  = snap_nxt[TX_LEN-1:0];
      cnt_nxt = '0;
    end else if (ncs_rise) begin
      sh_nxt = SH_IDLE;
    end else if (sh_state == SH_ACTIVE && sclk_fall) begin
      sa_nxt = {shift_a[TX_LEN-2:0], 1'b0};
      sb_nxt = {shift_b[TX_LEN-2:0], 1'b0};
      if (bit_cnt != W_CNT'(TX_LEN)) cnt_nxt = bit_cnt + W_CNT'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      conv_state     <= CONV_IDLE;
      tmr            <= '0;
      snapshot       <= '0;
      conv_count_out <= '0;
      adc_busy_out   <= 1'b0;
      sh_state       <= SH_IDLE;
      shift_a        <= '0;
      shift_b        <= '0;
      bit_cnt        <= '0;
    end else begin
      conv_state   <= conv_nxt;
      tmr          <= tmr_nxt;
      snapshot     <= snap_nxt;
      adc_busy_out <= (conv_state == CONV_BUSY);
      if (accept) conv_count_out <= conv_count_out + 16'd1;
      sh_state <= sh_nxt;
      shift_a  <= sa_nxt;
      shift_b  <= sb_nxt;
      bit_cnt  <= cnt_nxt;
    end
  end

  assign adc_data_a_out = (sh_state == SH_ACTIVE) & shift_a[TX_LEN-1];
  assign adc_data_b_out = (sh_state == SH_ACTIVE) & shift_b[TX_LEN-1];

endmodule
